// File: rtl/watch_display.sv
// watch_display: HH.MM multiplexed 7-segment driver with frame-coherent time snapshot.
// Ports: clk, rstn (async, active-low), hour[3:0], minute[5:0], disp_en -> an[3:0], seg[6:0], dp.
// an/seg/dp are all active-low. an[0]=min ones, an[1]=min tens, an[2]=hour ones, an[3]=hour tens.
// Optional: define COLON_BLINK_EN to blink dp on the hour-ones digit every BLINK_FRAMES frames.
module watch_display #(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] hour,
    input  logic [5:0] minute,
    input  logic       disp_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    generate
        if (SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_param
            $error("watch_display: illegal SCAN_DIV or BLINK_FRAMES");
        end
    endgenerate

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        s = BLANK;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    logic [PW-1:0] pres;
    logic [1:0]    idx;
    logic [3:0]    sh;
    logic [5:0]    sm;
    logic          wrap;
    logic          fwrap;

    assign wrap  = (pres == PLAST);
    // last edge of a frame: snapshot here so a whole frame shows one time
    assign fwrap = wrap && (idx == 2'd3);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pres <= '0;
            idx  <= '0;
            sh   <= '0;
            sm   <= '0;
        end else begin
            pres <= wrap ? '0 : pres + PW'(1);
            if (wrap) idx <= idx + 2'd1;
            if (fwrap) begin
                sh <= hour;
                sm <= minute;
            end
        end
    end

    logic       h_hi;
    logic       m_bad;
    logic [3:0] h_lo;
    logic [3:0] m_hi;
    logic [3:0] m_lo;

    always_comb begin
        h_hi  = (sh > 4'd9);
        h_lo  = h_hi ? (sh - 4'd10) : sh;
        m_bad = (sm > 6'd59);
        m_hi  = 4'(sm / 6'd10);
        m_lo  = 4'(sm % 6'd10);
    end

    logic [3:0] an_d;
    logic [6:0] seg_d;

    always_comb begin
        an_d  = 4'b1111;
        seg_d = BLANK;
        if (disp_en) begin
            an_d = ~(4'b0001 << idx);
            unique case (idx)
                2'd0:    seg_d = m_bad ? DASH : seg7(m_lo);
                2'd1:    seg_d = m_bad ? DASH : seg7(m_hi);
                2'd2:    seg_d = seg7(h_lo);
                default: seg_d = h_hi ? seg7(4'd1) : BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an  <= 4'b1111;
            seg <= BLANK;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

`ifdef COLON_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] fcnt;
    logic          flag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fcnt <= '0;
            flag <= 1'b0;
            dp   <= 1'b1;
        end else begin
            if (fwrap) begin
                if (fcnt == FLAST) begin
                    fcnt <= '0;
                    flag <= ~flag;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
            // lit only alongside the hour-ones digit
            dp <= ~(disp_en && flag && (idx == 2'd2));
        end
    end
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_watch_display.sv
// tb_watch_display: directed checks of scan order, decode, snapshot,
// disp_en gating, async reset and (when built with COLON_BLINK_EN) colon blink.
module tb_watch_display;

    localparam int SD = 4;
    localparam int FE = 4 * SD;
`ifdef COLON_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam logic [6:0] ZR = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] hour;
    logic [5:0] minute;
    logic       disp_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;
    int fno = 0;

    always #5 clk = ~clk;

    watch_display #(.SCAN_DIV(SD), .BLINK_FRAMES(2)) dut (
        .clk(clk),
        .rstn(rstn),
        .hour(hour),
        .minute(minute),
        .disp_en(disp_en),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // blink flag is set during frames 3-4, 7-8, ... with BLINK_FRAMES=2
    function automatic bit flag_on(input int f);
        return BLINK && ((((f - 1) / 2) % 2) == 1);
    endfunction

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input int nedge, input int cslot,
                         input logic [3:0] nh, input logic [5:0] nm);
        logic [6:0] sx [4];
        sx = '{s0, s1, s2, s3};
        fno++;
        for (int e = 0; e < nedge; e++) begin
            int s;
            logic [3:0] ea;
            logic edp;
            s = e / SD;
            ea = ~(4'b0001 << s);
            edp = !(s == 2 && flag_on(fno));
            tick();
            chk($sformatf("an f%0d e%0d", fno, e), 32'(an), 32'(ea));
            chk($sformatf("seg f%0d e%0d", fno, e), 32'(seg), 32'(sx[s]));
            chk($sformatf("dp f%0d e%0d", fno, e), 32'(dp), 32'(edp));
            if (s == cslot && (e % SD) == 0) begin
                hour = nh;
                minute = nm;
            end
        end
    endtask

    // disp_en low for 10 edges starting at the 2nd edge; inputs change while dark
    task automatic dark_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] sx [4];
        sx = '{s0, s1, s2, s3};
        fno++;
        for (int e = 0; e < FE; e++) begin
            int s;
            bit dk;
            logic [3:0] ea;
            logic [6:0] es;
            logic edp;
            s = e / SD;
            dk = (e >= 1 && e <= 10);
            ea = dk ? 4'b1111 : ~(4'b0001 << s);
            es = dk ? BL : sx[s];
            edp = !(s == 2 && !dk && flag_on(fno));
            tick();
            chk($sformatf("an dark e%0d", e), 32'(an), 32'(ea));
            chk($sformatf("seg dark e%0d", e), 32'(seg), 32'(es));
            chk($sformatf("dp dark e%0d", e), 32'(dp), 32'(edp));
            if (e == 0) disp_en = 1'b0;
            if (e == 4) begin
                hour = 4'd15;
                minute = 6'd63;
            end
            if (e == 10) disp_en = 1'b1;
        end
    endtask

    initial begin
        rstn = 1'b0;
        disp_en = 1'b1;
        hour = 4'd7;
        minute = 6'd42;
        repeat (2) @(posedge clk);
        #1;
        chk("rst an", 32'(an), 32'(4'b1111));
        chk("rst seg", 32'(seg), 32'(BL));
        chk("rst dp", 32'(dp), 32'(1'b1));
        rstn = 1'b1;

        frame(ZR, ZR, ZR, BL, FE, -1, 4'd0, 6'd0);
        hour = 4'd12;
        minute = 6'd5;
        frame(D2, D4, D7, BL, FE, -1, 4'd0, 6'd0);
        hour = 4'd3;
        minute = 6'd61;
        frame(D5, ZR, D2, D1, FE, -1, 4'd0, 6'd0);
        hour = 4'd9;
        minute = 6'd59;
        frame(DS, DS, D3, BL, FE, -1, 4'd0, 6'd0);
        frame(D9, D5, D9, BL, FE, 1, 4'd10, 6'd0);
        frame(ZR, ZR, ZR, D1, FE, -1, 4'd0, 6'd0);
        dark_frame(ZR, ZR, ZR, D1);
        frame(DS, DS, D5, D1, 6, -1, 4'd0, 6'd0);

        rstn = 1'b0;
        #1;
        chk("async an", 32'(an), 32'(4'b1111));
        chk("async seg", 32'(seg), 32'(BL));
        chk("async dp", 32'(dp), 32'(1'b1));
        tick();
        chk("held an", 32'(an), 32'(4'b1111));
        rstn = 1'b1;
        fno = 0;
        frame(ZR, ZR, ZR, BL, FE, -1, 4'd0, 6'd0);
        frame(DS, DS, D5, D1, FE, -1, 4'd0, 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
